mul_int_booth_seq: RTL and testbench

Parametrised, multi-cycle radix-4 Booth integer multiplier with a start/valid handshake and a per-operation signed or unsigned mode. It retires two multiplier bits per clock, so for WIDTH=32 it needs 17 iteration cycles instead of 32 unrolled add/shift stages in one cycle. It sits next to the single-cycle 32-bit multiplier in the integer datapath and is the default multiplier for timing-critical builds. The caller stalls on `busy` and collects the product when `valid` pulses.

---
 rtl/mul_pkg.sv | 29 ++
 rtl/booth_r4_enc.sv | 20 ++
 rtl/mul_int_booth_seq.sv | 137 +++++++++++++
 tb/tb_mul_int_booth_seq.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_pkg
// Shared types for the sequential Booth multiplier and its encoder.
// Revision: 1.0
// ---------------------------------------------------------------------------
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_ZERO = 3'd0,
        OP_POS1 = 3'd1,
        OP_POS2 = 3'd2,
        OP_NEG1 = 3'd3,
        OP_NEG2 = 3'd4
    } booth_op_e;

    // Radix-4 iterations needed for WIDTH-bit operands extended to WIDTH+2 bits
    function automatic int unsigned n_iter(input int unsigned width);
        return width / 2 + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_r4_enc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// booth_r4_enc
// Combinational radix-4 Booth recoder: {q[i+1], q[i], q[i-1]} -> neg/one/two.
// Revision: 1.0
// ---------------------------------------------------------------------------
module booth_r4_enc (
    input  logic [2:0] bits,
    output logic       neg,
    output logic       one,
    output logic       two
);

    // 3'b111 recodes to zero, so it must not raise neg
    assign neg = bits[2] & ~(bits[1] & bits[0]);
    assign one = bits[1] ^ bits[0];
    assign two = (bits == 3'b011) | (bits == 3'b100);

endmodule
`default_nettype wire

// File: rtl/mul_int_booth_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_int_booth_seq
// Multi-cycle radix-4 Booth multiplier, signed/unsigned per operation.
// Revision: 1.0
// ---------------------------------------------------------------------------
module mul_int_booth_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               valid,
    output logic [2*WIDTH-1:0] c
);

    localparam int E  = WIDTH + 2;
    localparam int N  = int'(n_iter(WIDTH));
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    state_e          state_q, state_d;
    logic [E:0]      acc_q, acc_d;
    logic [E-1:0]    q_q, q_d;
    logic            qm1_q, qm1_d;
    logic [E-1:0]    m_q, m_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] c_q, c_d;

    logic            w_neg, w_one, w_two;
    booth_op_e       w_op;
    logic [E-1:0]    w_a_ext, w_b_ext;
    logic [E:0]      w_m_ext, w_addend, w_sum, w_acc_run;
    logic [E-1:0]    w_q_run;

    booth_r4_enc u_enc (
        .bits ({q_q[1:0], qm1_q}),
        .neg  (w_neg),
        .one  (w_one),
        .two  (w_two)
    );

    assign w_a_ext = {{2{is_signed & a[WIDTH-1]}}, a};
    assign w_b_ext = {{2{is_signed & b[WIDTH-1]}}, b};
    assign w_m_ext = {m_q[E-1], m_q};

    always_comb begin
        w_op = OP_ZERO;
        if (w_two)
            w_op = w_neg ? OP_NEG2 : OP_POS2;
        else if (w_one)
            w_op = w_neg ? OP_NEG1 : OP_POS1;
    end

    always_comb begin
        w_addend = '0;
        case (w_op)
            OP_POS1: w_addend = w_m_ext;
            OP_POS2: w_addend = w_m_ext << 1;
            OP_NEG1: w_addend = -w_m_ext;
            OP_NEG2: w_addend = -(w_m_ext << 1);
            default: w_addend = '0;
        endcase
    end

    // Add, then arithmetic-shift {acc, q, q[-1]} right by two
    assign w_sum     = acc_q + w_addend;
    assign w_acc_run = {{2{w_sum[E]}}, w_sum[E:2]};
    assign w_q_run   = {w_sum[1:0], q_q[E-1:2]};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    acc_d   = '0;
                    q_d     = w_a_ext;
                    qm1_d   = 1'b0;
                    m_d     = w_b_ext;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                acc_d = w_acc_run;
                q_d   = w_q_run;
                qm1_d = q_q[1];
                cnt_d = cnt_q + CW'(1);
                // Capture on the final step so c is already stable throughout DONE
                if (cnt_q == C_LAST) begin
                    state_d = DONE;
                    c_d     = {w_acc_run[WIDTH-3:0], w_q_run};
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign valid = (state_q == DONE);
    assign c     = c_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_int_booth_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mul_int_booth_seq
// Directed checks of the Booth multiplier at WIDTH=32 and WIDTH=8.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mul_int_booth_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start32 = 1'b0, sgn32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, valid32;
    logic [63:0] c32;
    logic        start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, valid8;
    logic [15:0] c8;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    mul_int_booth_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .is_signed(sgn32),
        .a(a32), .b(b32), .busy(busy32), .valid(valid32), .c(c32)
    );

    mul_int_booth_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8),
        .a(a8), .b(b8), .busy(busy8), .valid(valid8), .c(c8)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=32 operation: product, latency, single pulse, return to idle
    task automatic run32(input string tag, input logic s, input logic [31:0] av,
                         input logic [31:0] bv, input logic [63:0] exp);
        int lat;
        sgn32 = s; a32 = av; b32 = bv; start32 = 1'b1;
        tick;
        start32 = 1'b0;
        lat = 1;
        while (!valid32 && lat < 40) begin
            tick;
            lat++;
        end
        chk({tag, "_c"}, c32, exp);
        chk({tag, "_lat"}, 64'(lat), 64'd18);
        tick;
        chk({tag, "_valid_drop"}, {63'd0, valid32}, 64'd0);
        chk({tag, "_idle"}, {63'd0, busy32}, 64'd0);
    endtask

    initial begin
        int nv;
        int first;
        int lat;

        // Reset state
        tick; tick;
        chk("rst_busy32", {63'd0, busy32}, 64'd0);
        chk("rst_valid32", {63'd0, valid32}, 64'd0);
        chk("rst_c32", c32, 64'd0);
        chk("rst_busy8", {63'd0, busy8}, 64'd0);
        chk("rst_c8", {48'd0, c8}, 64'd0);
        rst = 1'b0;
        tick;

        // Signed, unsigned and extreme operand products
        run32("s_m7x3", 1'b1, 32'hFFFF_FFF9, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFEB);
        run32("u_max2", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run32("s_m1m1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
        run32("s_min2", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run32("u_hix2", 1'b0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000);
        run32("s_maxmin", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
        run32("u_misc", 1'b0, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780);

        // start during RUN is ignored; re-issue once idle
        sgn32 = 1'b0; a32 = 32'd5; b32 = 32'd6; start32 = 1'b1;
        nv = 0; first = 0;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            tick;
            start32 = (cyc == 4);
            if (cyc == 4) begin a32 = 32'd9; b32 = 32'd9; end
            if (valid32) begin
                nv++;
                if (first == 0) first = cyc;
            end
        end
        chk("ign_first_valid", 64'(first), 64'd18);
        chk("ign_nvalid", 64'(nv), 64'd1);
        chk("ign_c30", c32, 64'd30);
        tick;
        chk("ign_c19_valid", {63'd0, valid32}, 64'd0);
        chk("ign_c19_busy", {63'd0, busy32}, 64'd0);
        a32 = 32'd9; b32 = 32'd9; start32 = 1'b1;
        nv = 0; first = 0;
        for (int cyc = 20; cyc <= 37; cyc++) begin
            tick;
            start32 = 1'b0;
            if (valid32) begin
                nv++;
                if (first == 0) first = cyc;
            end
        end
        chk("reissue_first_valid", 64'(first), 64'd37);
        chk("reissue_nvalid", 64'(nv), 64'd1);
        chk("reissue_c81", c32, 64'd81);
        tick;

        // Reset mid-operation discards it
        sgn32 = 1'b0; a32 = 32'd5; b32 = 32'd7; start32 = 1'b1;
        tick;
        start32 = 1'b0;
        for (int cyc = 2; cyc <= 5; cyc++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mid_rst_busy", {63'd0, busy32}, 64'd0);
        chk("mid_rst_valid", {63'd0, valid32}, 64'd0);
        chk("mid_rst_c", c32, 64'd0);
        nv = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            tick;
            if (valid32) nv++;
        end
        chk("mid_rst_no_valid", 64'(nv), 64'd0);
        run32("post_rst_2x3", 1'b0, 32'd2, 32'd3, 64'd6);

        // WIDTH=8 signed boundary
        sgn8 = 1'b1; a8 = 8'h80; b8 = 8'h7F; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        lat = 1;
        while (!valid8 && lat < 20) begin
            tick;
            lat++;
        end
        chk("w8_c", {48'd0, c8}, 64'h0000_0000_0000_C080);
        chk("w8_lat", 64'(lat), 64'd6);
        tick;
        chk("w8_valid_drop", {63'd0, valid8}, 64'd0);
        chk("w8_idle", {63'd0, busy8}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
